// File: rtl/sparc_exu_yreg_pkg.sv
`default_nettype none
// ============================================================================
// Module : sparc_exu_yreg_pkg
// Brief  : Source-select encoding and priority helpers for the Y register file
// Rev    : 1.0
// ============================================================================
package sparc_exu_yreg_pkg;

    typedef enum logic [1:0] {
        SEL_W2   = 2'd0,
        SEL_G    = 2'd1,
        SEL_SHF  = 2'd2,
        SEL_HOLD = 2'd3
    } yreg_sel_e;

    localparam int unsigned SEL_NUM = 4;

    // Priority order: W2 commit > G write > shift > hold
    function automatic yreg_sel_e yreg_pick(input logic w2, input logic g, input logic shf);
        if (w2)
            return SEL_W2;
        else if (g)
            return SEL_G;
        else if (shf)
            return SEL_SHF;
        return SEL_HOLD;
    endfunction

    function automatic logic [SEL_NUM-1:0] yreg_onehot(input yreg_sel_e sel);
        return SEL_NUM'(1) << sel;
    endfunction

    function automatic logic yreg_multi_hit(input logic w2, input logic g, input logic shf);
        return (w2 & g) | (w2 & shf) | (g & shf);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sparc_exu_yreg_entry.sv
`default_nettype none
// ============================================================================
// Module : sparc_exu_yreg_entry
// Brief  : One thread's Y register with prioritised next-value mux and
//          same-thread collision detect
// Rev    : 1.0
// ============================================================================
module sparc_exu_yreg_entry
    import sparc_exu_yreg_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             arst_l,
    input  logic             w2_en_i,
    input  logic [WIDTH-1:0] w2_data_i,
    input  logic             g_en_i,
    input  logic [WIDTH-1:0] g_data_i,
    input  logic             shf_en_i,
    input  logic             shf_bit_i,
    output logic [WIDTH-1:0] y_o,
    output logic [WIDTH-1:0] y_next_o,
    output logic             collide_o
);

    logic [WIDTH-1:0]   y_q;
    logic [WIDTH-1:0]   y_d;
    logic [SEL_NUM-1:0] sel_oh;
    logic [WIDTH-1:0]   shf_val;

    assign shf_val = {shf_bit_i, y_q[WIDTH-1:1]};

    always_comb begin
        sel_oh = yreg_onehot(yreg_pick(w2_en_i, g_en_i, shf_en_i));
        y_d    = ({WIDTH{sel_oh[SEL_W2]}}   & w2_data_i)
               | ({WIDTH{sel_oh[SEL_G]}}    & g_data_i)
               | ({WIDTH{sel_oh[SEL_SHF]}}  & shf_val)
               | ({WIDTH{sel_oh[SEL_HOLD]}} & y_q);
    end

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l)
            y_q <= '0;
        else
            y_q <= y_d;
    end

    assign y_o       = y_q;
    assign y_next_o  = y_d;
    assign collide_o = yreg_multi_hit(w2_en_i, g_en_i, shf_en_i);

endmodule
`default_nettype wire

// File: rtl/sparc_exu_yreg_file.sv
`default_nettype none
// ============================================================================
// Module : sparc_exu_yreg_file
// Brief  : Per-thread Y register file with W->W2 write pipe, G write, MULScc
//          shift, write-pending scoreboard, optional read bypass
// Rev    : 1.0
// ============================================================================
module sparc_exu_yreg_file
    import sparc_exu_yreg_pkg::*;
#(
    parameter int NTHR   = 4,
    parameter int WIDTH  = 32,
    parameter int TIDW   = $clog2(NTHR),
    parameter bit BYPASS = 1'b0
) (
    input  logic             clk,
    input  logic             arst_l,
    input  logic             wr_w_vld,
    input  logic [TIDW-1:0]  wr_w_tid,
    input  logic [WIDTH-1:0] wr_w_data,
    input  logic             wr_w2_kill,
    input  logic             wr_g_vld,
    input  logic [TIDW-1:0]  wr_g_tid,
    input  logic [WIDTH-1:0] wr_g_data,
    input  logic             shf_g_vld,
    input  logic [TIDW-1:0]  shf_g_tid,
    input  logic             shf_g_bit,
    input  logic [TIDW-1:0]  rd_tid_e,
    output logic [WIDTH-1:0] rd_data_e,
    output logic [NTHR-1:0]  yreg_lsb_l,
    output logic [NTHR-1:0]  wr_pend,
    output logic             wr_collide
);

    logic             w2_vld_q;
    logic [TIDW-1:0]  w2_tid_q;
    logic [WIDTH-1:0] w2_data_q;
    logic             collide_q;
    logic             collide_d;
    logic             w2_commit;

    logic [WIDTH-1:0] y_q_arr [NTHR];
    logic [WIDTH-1:0] y_d_arr [NTHR];
    logic [NTHR-1:0]  coll_vec;

    // Out-of-range tids never match a thread decode, so they fall away naturally
    assign w2_commit = w2_vld_q & ~wr_w2_kill;
    assign collide_d = |coll_vec;

    always_ff @(posedge clk or negedge arst_l) begin
        if (!arst_l) begin
            w2_vld_q  <= 1'b0;
            w2_tid_q  <= '0;
            w2_data_q <= '0;
            collide_q <= 1'b0;
        end else begin
            w2_vld_q  <= wr_w_vld;
            w2_tid_q  <= wr_w_tid;
            w2_data_q <= wr_w_data;
            collide_q <= collide_d;
        end
    end

    generate
        for (genvar t = 0; t < NTHR; t++) begin : g_thr
            localparam logic [TIDW-1:0] C_TID = TIDW'(t);

            logic w2_hit;
            logic g_hit;
            logic shf_hit;

            assign w2_hit  = w2_commit & (w2_tid_q == C_TID);
            assign g_hit   = wr_g_vld  & (wr_g_tid  == C_TID);
            assign shf_hit = shf_g_vld & (shf_g_tid == C_TID);

            sparc_exu_yreg_entry #(
                .WIDTH (WIDTH)
            ) u_entry (
                .clk       (clk),
                .arst_l    (arst_l),
                .w2_en_i   (w2_hit),
                .w2_data_i (w2_data_q),
                .g_en_i    (g_hit),
                .g_data_i  (wr_g_data),
                .shf_en_i  (shf_hit),
                .shf_bit_i (shf_g_bit),
                .y_o       (y_q_arr[t]),
                .y_next_o  (y_d_arr[t]),
                .collide_o (coll_vec[t])
            );

            assign wr_pend[t]    = w2_vld_q & (w2_tid_q == C_TID);
            assign yreg_lsb_l[t] = ~y_q_arr[t][0];
        end
    endgenerate

    always_comb begin
        rd_data_e = '0;
        for (int t = 0; t < NTHR; t++) begin
            if (rd_tid_e == TIDW'(t))
                rd_data_e = BYPASS ? y_d_arr[t] : y_q_arr[t];
        end
    end

    assign wr_collide = collide_q;

endmodule
`default_nettype wire

// File: tb/tb_sparc_exu_yreg_file.sv
`default_nettype none
// ============================================================================
// Module : tb_sparc_exu_yreg_file
// Brief  : Directed bench for the Y register file (4x32 plain, 4x32 bypass,
//          8x64 shift sweep)
// Rev    : 1.0
// ============================================================================
module tb_sparc_exu_yreg_file;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        arst_l;
    logic        wr_w_vld, wr_w2_kill, wr_g_vld, shf_g_vld, shf_g_bit;
    logic [1:0]  wr_w_tid, wr_g_tid, shf_g_tid, rd_tid_e;
    logic [31:0] wr_w_data, wr_g_data;
    logic [31:0] rd_data_e, rd_data_bp;
    logic [3:0]  yreg_lsb_l, lsb_bp, wr_pend, pend_bp;
    logic        wr_collide, coll_bp;

    logic        x_shf_vld, x_shf_bit, x_w_vld, x_kill, x_g_vld;
    logic [2:0]  x_shf_tid, x_rd_tid, x_w_tid, x_g_tid;
    logic [63:0] x_w_data, x_g_data, x_rd_data;
    logic [7:0]  x_lsb_l, x_pend;
    logic        x_coll;

    int n_vec = 0;
    int n_err = 0;

    sparc_exu_yreg_file #(.NTHR(4), .WIDTH(32), .TIDW(2), .BYPASS(1'b0)) dut (
        .clk(clk), .arst_l(arst_l),
        .wr_w_vld(wr_w_vld), .wr_w_tid(wr_w_tid), .wr_w_data(wr_w_data), .wr_w2_kill(wr_w2_kill),
        .wr_g_vld(wr_g_vld), .wr_g_tid(wr_g_tid), .wr_g_data(wr_g_data),
        .shf_g_vld(shf_g_vld), .shf_g_tid(shf_g_tid), .shf_g_bit(shf_g_bit),
        .rd_tid_e(rd_tid_e), .rd_data_e(rd_data_e),
        .yreg_lsb_l(yreg_lsb_l), .wr_pend(wr_pend), .wr_collide(wr_collide)
    );

    sparc_exu_yreg_file #(.NTHR(4), .WIDTH(32), .TIDW(2), .BYPASS(1'b1)) dut_bp (
        .clk(clk), .arst_l(arst_l),
        .wr_w_vld(wr_w_vld), .wr_w_tid(wr_w_tid), .wr_w_data(wr_w_data), .wr_w2_kill(wr_w2_kill),
        .wr_g_vld(wr_g_vld), .wr_g_tid(wr_g_tid), .wr_g_data(wr_g_data),
        .shf_g_vld(shf_g_vld), .shf_g_tid(shf_g_tid), .shf_g_bit(shf_g_bit),
        .rd_tid_e(rd_tid_e), .rd_data_e(rd_data_bp),
        .yreg_lsb_l(lsb_bp), .wr_pend(pend_bp), .wr_collide(coll_bp)
    );

    sparc_exu_yreg_file #(.NTHR(8), .WIDTH(64), .TIDW(3), .BYPASS(1'b0)) dut_w (
        .clk(clk), .arst_l(arst_l),
        .wr_w_vld(x_w_vld), .wr_w_tid(x_w_tid), .wr_w_data(x_w_data), .wr_w2_kill(x_kill),
        .wr_g_vld(x_g_vld), .wr_g_tid(x_g_tid), .wr_g_data(x_g_data),
        .shf_g_vld(x_shf_vld), .shf_g_tid(x_shf_tid), .shf_g_bit(x_shf_bit),
        .rd_tid_e(x_rd_tid), .rd_data_e(x_rd_data),
        .yreg_lsb_l(x_lsb_l), .wr_pend(x_pend), .wr_collide(x_coll)
    );

    task automatic idle();
        wr_w_vld = 0; wr_w_tid = 0; wr_w_data = 0; wr_w2_kill = 0;
        wr_g_vld = 0; wr_g_tid = 0; wr_g_data = 0;
        shf_g_vld = 0; shf_g_tid = 0; shf_g_bit = 0;
        x_w_vld = 0; x_w_tid = 0; x_w_data = 0; x_kill = 0;
        x_g_vld = 0; x_g_tid = 0; x_g_data = 0;
        x_shf_vld = 0; x_shf_tid = 0; x_shf_bit = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rd_tid_e = 0; x_rd_tid = 0;
        arst_l = 1'b1;
        @(posedge clk);
        #2 arst_l = 1'b0;
        #1;
        for (int t = 0; t < 4; t++) begin
            rd_tid_e = 2'(t);
            #1;
            n_vec++;
            if (rd_data_e !== 32'h0) begin
                n_err++;
                $display("FAIL reset_rd tid%0d: got %h want 0", t, rd_data_e);
            end
        end
        n_vec++;
        if (yreg_lsb_l !== 4'hF) begin
            n_err++;
            $display("FAIL reset_lsb: got %b want 1111", yreg_lsb_l);
        end
        n_vec++;
        if (wr_pend !== 4'h0 || wr_collide !== 1'b0) begin
            n_err++;
            $display("FAIL reset_pend_coll: got pend=%b coll=%b want 0000/0", wr_pend, wr_collide);
        end
        @(posedge clk);
        #1 arst_l = 1'b1;
        tick();
    endtask

    task automatic test_w_write();
        wr_w_vld = 1; wr_w_tid = 2'd1; wr_w_data = 32'hDEADBEEF;
        tick();
        idle();
        rd_tid_e = 2'd1;
        #1;
        n_vec++;
        if (wr_pend !== 4'b0010 || pend_bp !== 4'b0010) begin
            n_err++;
            $display("FAIL w_pend: got %b/%b want 0010", wr_pend, pend_bp);
        end
        n_vec++;
        if (rd_data_e !== 32'h0) begin
            n_err++;
            $display("FAIL w_early: got %h want 0", rd_data_e);
        end
        tick();
        n_vec++;
        if (rd_data_e !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL w_commit: got %h want deadbeef", rd_data_e);
        end
        n_vec++;
        if (wr_pend !== 4'b0000 || yreg_lsb_l !== 4'b1101) begin
            n_err++;
            $display("FAIL w_after: got pend=%b lsb=%b want 0000/1101", wr_pend, yreg_lsb_l);
        end
    endtask

    task automatic test_kill();
        wr_w_vld = 1; wr_w_tid = 2'd2; wr_w_data = 32'h1234;
        tick();
        idle();
        wr_w2_kill = 1;
        n_vec++;
        if (wr_pend !== 4'b0100) begin
            n_err++;
            $display("FAIL kill_pend: got %b want 0100", wr_pend);
        end
        tick();
        idle();
        rd_tid_e = 2'd2;
        #1;
        n_vec++;
        if (rd_data_e !== 32'h0) begin
            n_err++;
            $display("FAIL kill_y2: got %h want 0", rd_data_e);
        end
        n_vec++;
        if (wr_pend !== 4'b0000 || wr_collide !== 1'b0) begin
            n_err++;
            $display("FAIL kill_flags: got pend=%b coll=%b want 0000/0", wr_pend, wr_collide);
        end
    endtask

    task automatic test_collide();
        wr_w_vld = 1; wr_w_tid = 2'd0; wr_w_data = 32'hA;
        wr_g_vld = 1; wr_g_tid = 2'd3; wr_g_data = 32'h3;
        tick();
        idle();
        wr_g_vld = 1; wr_g_tid = 2'd0; wr_g_data = 32'hB;
        shf_g_vld = 1; shf_g_tid = 2'd3; shf_g_bit = 1'b1;
        rd_tid_e = 2'd3;
        #1;
        n_vec++;
        if (wr_collide !== 1'b0 || rd_data_e !== 32'h3) begin
            n_err++;
            $display("FAIL coll_setup: got coll=%b y3=%h want 0/3", wr_collide, rd_data_e);
        end
        tick();
        idle();
        rd_tid_e = 2'd0;
        #1;
        n_vec++;
        if (rd_data_e !== 32'hA) begin
            n_err++;
            $display("FAIL coll_y0: got %h want a", rd_data_e);
        end
        rd_tid_e = 2'd3;
        #1;
        n_vec++;
        if (rd_data_e !== 32'h80000001) begin
            n_err++;
            $display("FAIL coll_y3_shift: got %h want 80000001", rd_data_e);
        end
        n_vec++;
        if (wr_collide !== 1'b1 || coll_bp !== 1'b1 || yreg_lsb_l !== 4'b0101) begin
            n_err++;
            $display("FAIL coll_flag: got coll=%b/%b lsb=%b want 1/1/0101", wr_collide, coll_bp, yreg_lsb_l);
        end
        tick();
        n_vec++;
        if (wr_collide !== 1'b0) begin
            n_err++;
            $display("FAIL coll_clear: got %b want 0", wr_collide);
        end
    endtask

    task automatic test_bypass();
        rd_tid_e = 2'd2;
        wr_g_vld = 1; wr_g_tid = 2'd2; wr_g_data = 32'h55;
        #1;
        n_vec++;
        if (rd_data_bp !== 32'h55) begin
            n_err++;
            $display("FAIL bypass_on: got %h want 55", rd_data_bp);
        end
        n_vec++;
        if (rd_data_e !== 32'h0 || lsb_bp !== 4'b0101) begin
            n_err++;
            $display("FAIL bypass_off: got rd=%h lsb=%b want 0/0101", rd_data_e, lsb_bp);
        end
        tick();
        idle();
        n_vec++;
        if (rd_data_e !== 32'h55 || yreg_lsb_l !== 4'b0001) begin
            n_err++;
            $display("FAIL bypass_after: got rd=%h lsb=%b want 55/0001", rd_data_e, yreg_lsb_l);
        end
    endtask

    task automatic test_back_to_back();
        wr_w_vld = 1; wr_w_tid = 2'd0; wr_w_data = 32'h11;
        tick();
        wr_w_tid = 2'd1; wr_w_data = 32'h22;
        n_vec++;
        if (wr_pend !== 4'b0001) begin
            n_err++;
            $display("FAIL b2b_pend0: got %b want 0001", wr_pend);
        end
        tick();
        idle();
        rd_tid_e = 2'd0;
        #1;
        n_vec++;
        if (rd_data_e !== 32'h11 || wr_pend !== 4'b0010) begin
            n_err++;
            $display("FAIL b2b_first: got y0=%h pend=%b want 11/0010", rd_data_e, wr_pend);
        end
        tick();
        rd_tid_e = 2'd1;
        #1;
        n_vec++;
        if (rd_data_e !== 32'h22 || wr_pend !== 4'b0000) begin
            n_err++;
            $display("FAIL b2b_second: got y1=%h pend=%b want 22/0000", rd_data_e, wr_pend);
        end
    endtask

    task automatic test_g_over_shift();
        wr_g_vld = 1; wr_g_tid = 2'd1; wr_g_data = 32'h4;
        shf_g_vld = 1; shf_g_tid = 2'd1; shf_g_bit = 1'b1;
        tick();
        idle();
        rd_tid_e = 2'd1;
        #1;
        n_vec++;
        if (rd_data_e !== 32'h4 || wr_collide !== 1'b1) begin
            n_err++;
            $display("FAIL g_over_shf: got y1=%h coll=%b want 4/1", rd_data_e, wr_collide);
        end
        tick();
    endtask

    task automatic test_sweep();
        logic [63:0] m [8];
        logic [7:0]  lsb_exp;
        logic        b;
        for (int t = 0; t < 8; t++) m[t] = 64'h0;
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 64; i++) begin
                b = 1'($urandom_range(0, 1));
                x_shf_vld = 1; x_shf_tid = 3'(t); x_shf_bit = b;
                m[t] = {b, m[t][63:1]};
                tick();
            end
        end
        idle();
        tick();
        for (int t = 0; t < 8; t++) begin
            x_rd_tid = 3'(t);
            #1;
            n_vec++;
            if (x_rd_data !== m[t]) begin
                n_err++;
                $display("FAIL sweep_y%0d: got %h want %h", t, x_rd_data, m[t]);
            end
        end
        for (int t = 0; t < 8; t++) lsb_exp[t] = ~m[t][0];
        n_vec++;
        if (x_lsb_l !== lsb_exp || x_pend !== 8'h0 || x_coll !== 1'b0) begin
            n_err++;
            $display("FAIL sweep_flags: got lsb=%b pend=%b coll=%b want %b/0/0", x_lsb_l, x_pend, x_coll, lsb_exp);
        end
    endtask

    initial begin
        arst_l = 1'b1;
        idle();
        rd_tid_e = 0;
        x_rd_tid = 0;
        test_reset();
        test_w_write();
        test_kill();
        test_collide();
        test_bypass();
        test_back_to_back();
        test_g_over_shift();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
